// File: rtl/dadda_final_adder_pipe_pkg.sv
// dadda_final_adder_pipe_pkg: shared width default and S1 stage payload for the final adder pipe
package dadda_final_adder_pipe_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int MAX_HALF  = 64;
   // Fields are sized for the widest supported slice; narrower builds keep the upper bits zero.
   typedef struct packed {
      logic [MAX_HALF-1:0] lo_sum;
      logic                lo_c;
      logic [MAX_HALF-1:0] a_hi;
      logic [MAX_HALF-1:0] b_hi;
   } s1_payload_t;
endpackage

// File: rtl/dadda_final_adder_pipe_cla.sv
// dadda_final_adder_pipe_cla: N-bit carry-lookahead adder built from 4-bit lookahead groups
module dadda_final_adder_pipe_cla #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   logic [N/4:0] gc;
   assign gc[0] = cin;
   for (genvar g = 0; g < N/4; g++) begin : grp
      logic [3:0] gen, prp, c;
      assign gen  = a[4*g +: 4] & b[4*g +: 4];
      assign prp  = a[4*g +: 4] ^ b[4*g +: 4];
      assign c[0] = gc[g];
      assign c[1] = gen[0] | (prp[0] & gc[g]);
      assign c[2] = gen[1] | (prp[1] & gen[0]) | ((&prp[1:0]) & gc[g]);
      assign c[3] = gen[2] | (prp[2] & gen[1]) | ((&prp[2:1]) & gen[0]) | ((&prp[2:0]) & gc[g]);
      assign gc[g+1] = gen[3] | (prp[3] & gen[2]) | ((&prp[3:2]) & gen[1])
                     | ((&prp[3:1]) & gen[0]) | ((&prp) & gc[g]);
      assign sum[4*g +: 4] = prp ^ c;
   end
   assign cout = gc[N/4];
endmodule

// File: rtl/dadda_final_adder_pipe.sv
// dadda_final_adder_pipe: two-stage split final adder for Dadda sum/carry rows with valid/ready flow control
module dadda_final_adder_pipe
   import dadda_final_adder_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);
   localparam int HALF = WIDTH / 2;
   s1_payload_t     s1_q;
   logic            s1_valid, s1_adv, accept;
   logic [HALF-1:0] lo_sum, hi_sum;
   logic            lo_cout, hi_cout;
   logic            unused_s1;
   assign s1_adv    = s1_valid & (~out_valid | out_ready);
   assign in_ready  = ~s1_valid | s1_adv;
   assign accept    = in_valid & in_ready;
   assign unused_s1 = ^s1_q;
   dadda_final_adder_pipe_cla #(.N(HALF)) u_lo (
      .a    (in_a[HALF-1:0]),
      .b    (in_b[HALF-1:0]),
      .cin  (1'b0),
      .sum  (lo_sum),
      .cout (lo_cout)
   );
   dadda_final_adder_pipe_cla #(.N(HALF)) u_hi (
      .a    (s1_q.a_hi[HALF-1:0]),
      .b    (s1_q.b_hi[HALF-1:0]),
      .cin  (s1_q.lo_c),
      .sum  (hi_sum),
      .cout (hi_cout)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         s1_valid  <= accept | (s1_valid & ~s1_adv);
         out_valid <= s1_adv | (out_valid & ~out_ready);
      end
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_q <= '{lo_sum: MAX_HALF'(lo_sum),
                   lo_c:   lo_cout,
                   a_hi:   MAX_HALF'(in_a[WIDTH-1:HALF]),
                   b_hi:   MAX_HALF'(in_b[WIDTH-1:HALF])};
      end
   end
   // Output registers are reset so the result bus reads zero while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sum  <= '0;
         out_cout <= 1'b0;
      end else if (s1_adv) begin
         out_sum  <= {hi_sum, s1_q.lo_sum[HALF-1:0]};
         out_cout <= hi_cout;
      end
   end
endmodule
